stack_unit: RTL and testbench
=============================

// Module: stack_unit
// PURPOSE
// Operand stack of the stack-based multicycle CPU; consumes the push/pop/tos strobes
// issued by the Controller FSM and supplies top-of-stack data to the ALU/memory datapath.
// LIFO register file with synchronous reset, a registered read port, full/empty status
// and sticky overflow/underflow error flags.
// PARAMETERS
// WIDTH  8  data word width in bits
// DEPTH  8  number of stack entries; power of two, >= 2
// PTRW   3  pointer width, log2(DEPTH)
// PORTS
// clk    in   1        rising-edge clock
// rst    in   1        synchronous reset, active-high
// push   in   1        write din to the stack top this cycle
// pop    in   1        remove the top entry and register it on dout
// tos    in   1        register the top entry on dout without removing it
// din    in   WIDTH    push data
// dout   out  WIDTH    registered read data
// empty  out  1        count == 0
// full   out  1        count == DEPTH
// count  out  PTRW+1   number of valid entries
// ovf    out  1        sticky flag: push attempted while full
// unf    out  1        sticky flag: pop or tos attempted while empty
// BEHAVIOUR
// - One clock and one reset domain. Reset is synchronous and active-high on clk.
// - Reset: count=0, dout=0, ovf=0, unf=0, so empty=1 and full=0. Storage contents are
//   not cleared. Reset has priority over every strobe in the same cycle.
// - empty and full are decoded combinationally from count; no added latency.
// - Storage is mem[0..DEPTH-1]; the top entry is mem[count-1].
// - Read latency is 1 cycle: dout changes on the edge that samples pop/tos and holds
//   its value in every other cycle.
// - Single-cycle operations (sampled on the rising edge of clk):
//   * push only, not full: mem[count]<=din; count<=count+1.
//   * push only, full: no write; count unchanged; ovf<=1.
//   * pop only, not empty: dout<=mem[count-1]; count<=count-1.
//   * pop, empty: dout unchanged; count unchanged; unf<=1.
//   * tos, not empty: dout<=mem[count-1]; count unchanged.
//   * tos, empty: dout unchanged; unf<=1.
// - Simultaneous strobes:
//   * push+pop, not empty: dout<=old mem[count-1]; mem[count-1]<=din; count unchanged.
//     This case is not an overflow, even when the stack is full.
//   * push+pop, empty: acts as push only (mem[0]<=din, count<=1); unf<=1.
//   * tos together with pop: pop governs and tos is ignored.
//   * tos with push only: dout<=pre-push top, then the push proceeds as normal.
//     If the stack is empty, unf<=1 and the push still proceeds.
// - The pointer never wraps: count saturates at 0 and at DEPTH. A rejected operation
//   leaves count and storage untouched.
// - ovf and unf stay set until rst. They are for debug and bench checking only.
// - Reset mid-sequence drops all entries. The stack behaves as empty from the next cycle.
// - A later feature may add a no-op-on-idle guarantee; today idle cycles (no strobes)
//   hold all state.
// TESTING
// 1 rst high 2 cycles -> count=0, empty=1, full=0, dout=0, ovf=0, unf=0.
// 2 push 8'h11, 8'h22, 8'h33 on consecutive cycles; then tos -> dout=8'h33, count=3;
//   then pop x3 -> dout 33, 22, 11; empty=1 after the 3rd pop.
// 3 push 8 values 8'h01..8'h08 -> full=1, count=8; push 8'h99 -> count=8, ovf=1;
//   pop -> dout=8'h08.
// 4 after reset, pop -> unf=1, dout=0, count=0; tos -> dout unchanged;
//   unf stays 1 until rst.
// 5 push 8'hA0, then push+pop with din=8'hB0 -> dout=8'hA0, count=1; next tos -> dout=8'hB0.
// 6 push 8'h55, 8'h66; rst asserted together with a push -> count=0, dout=0;
//   next pop -> unf=1.

Source files
------------

// File: rtl/stack_unit.sv
// Operand stack for the stack CPU. It is a LIFO register file with a registered read port,
// full/empty status decoded from the entry count, and sticky overflow/underflow flags.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int PTRW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [PTRW:0]    count,
  output logic             ovf,
  output logic             unf
);

  localparam logic [PTRW:0] CNT_ONE  = {{PTRW{1'b0}}, 1'b1};
  localparam logic [PTRW:0] CNT_FULL = (PTRW+1)'(DEPTH);
  localparam logic [PTRW-1:0] PTR_ONE = {{(PTRW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTRW:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             not_empty;
  logic             is_full;
  logic [PTRW-1:0]  top_addr;
  logic [WIDTH-1:0] top_data;
  logic             wr_en;
  logic [PTRW-1:0]  wr_addr;

  // When count is DEPTH, the low pointer bits wrap to zero, so subtracting one still addresses the top entry.
  assign not_empty = |count_q;
  assign is_full   = (count_q == CNT_FULL);
  assign top_addr  = count_q[PTRW-1:0] - PTR_ONE;
  assign top_data  = mem_q[top_addr];

  // Next-state decode for count, the read register, the error flags and the storage write.
  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_addr = count_q[PTRW-1:0];
    if (pop) begin
      if (not_empty) begin
        dout_d = top_data;
        if (push) begin
          wr_en   = 1'b1;
          wr_addr = top_addr;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end else begin
        unf_d = 1'b1;
        if (push) begin
          wr_en   = 1'b1;
          wr_addr = {PTRW{1'b0}};
          count_d = CNT_ONE;
        end else begin
          count_d = count_q;
        end
      end
    end else begin
      if (tos) begin
        if (not_empty) begin
          dout_d = top_data;
        end else begin
          unf_d = 1'b1;
        end
      end else begin
        dout_d = dout_q;
      end
      if (push) begin
        if (!is_full) begin
          wr_en   = 1'b1;
          wr_addr = count_q[PTRW-1:0];
          count_d = count_q + CNT_ONE;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        wr_en = 1'b0;
      end
    end
  end

  // Control and status registers. Reset takes priority over every strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {(PTRW+1){1'b0}};
      dout_q  <= {WIDTH{1'b0}};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not cleared by reset. A reset cycle blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_q[wr_addr] <= din;
    end
  end

  assign dout  = dout_q;
  assign count = count_q;
  assign empty = ~not_empty;
  assign full  = is_full;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit. Each directed vector queues its hand-computed post-edge state,
// and a monitor compares that state with the DUT one edge later.
module tb_stack_unit;

  logic       clk = 1'b0;
  logic       rst, push, pop, tos;
  logic [7:0] din;
  logic [7:0] dout;
  logic       empty, full, ovf, unf;
  logic [3:0] count;

  typedef struct {
    int         id;
    logic [7:0] dout;
    logic [3:0] count;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_id = 0;

  stack_unit #(.WIDTH(8), .DEPTH(8), .PTRW(3)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .din(din),
    .dout(dout), .empty(empty), .full(full), .count(count), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, id, act, req);
    end
  endtask

  // Monitor: the DUT state is sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dout",  e.id, dout, e.dout);
      chk("count", e.id, {4'h0, count}, {4'h0, e.count});
      chk("empty", e.id, {7'h0, empty}, {7'h0, (e.count == 4'd0)});
      chk("full",  e.id, {7'h0, full},  {7'h0, (e.count == 4'd8)});
      chk("ovf",   e.id, {7'h0, ovf}, {7'h0, e.ovf});
      chk("unf",   e.id, {7'h0, unf}, {7'h0, e.unf});
    end
  end

  task automatic step(input logic r, input logic pu, input logic po, input logic t,
                      input logic [7:0] d, input logic [7:0] ed, input logic [3:0] ec,
                      input logic eo, input logic eu);
    exp_t e;
    @(negedge clk);
    rst = r; push = pu; pop = po; tos = t; din = d;
    vec_id++;
    e.id = vec_id; e.dout = ed; e.count = ec; e.ovf = eo; e.unf = eu;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; tos = 1'b0; din = 8'h00;
    // 1: reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0);
    // 2: push three values, peek, then pop them all
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 8'h00, 4'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 8'h00, 4'd2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 8'h00, 4'd3, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h33, 4'd3, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 4'd2, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h22, 4'd1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h11, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h11, 4'd0, 1'b0, 1'b0);
    // 3: fill to full, overflow, pop, then push+pop at full
    for (int i = 1; i <= 8; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'(i), 8'h11, 4'(i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h99, 8'h11, 4'd8, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h08, 4'd7, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h09, 8'h08, 4'd8, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'hAA, 8'h09, 4'd8, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hAA, 4'd8, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hAA, 4'd7, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h07, 4'd7, 1'b1, 1'b0);
    // 4: underflow after reset; unf is sticky
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1);
    // 5: push+pop replaces the top; tos+pop; push+pop when empty; tos+push
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hA0, 8'h00, 4'd1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'hB0, 8'hA0, 4'd1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hB0, 4'd1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hB0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'hC0, 8'hB0, 4'd1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'hD0, 8'hC0, 4'd2, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hD0, 4'd2, 1'b0, 1'b1);
    // 6: reset beats a simultaneous push
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 8'h00, 4'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h66, 8'h00, 4'd2, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h66, 4'd2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h77, 8'h00, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1);
    // tos+push on empty: unf is set and the push still proceeds
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h42, 8'h00, 4'd1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h42, 4'd1, 1'b0, 1'b1);
    // push+pop at full without a prior overflow must not set ovf
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h10 + 8'(i), 8'h00, 4'(i + 1), 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'hEE, 8'h17, 4'd8, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hEE, 4'd8, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hEE, 4'd8, 1'b0, 1'b0);

    @(negedge clk);
    push = 1'b0; pop = 1'b0; tos = 1'b0; rst = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
